// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cpu_pkg
//  Purpose : Opcode constants, instruction field positions and the fetch-state
//            encoding shared by the fetch sequencer and the control unit (CU).
//            CU imports the same opcode constants so both agree on decoding.
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int OPC_W  = 4;
   localparam int ADDR_W = 6;

   // Opcode map. 0001..1011 are executed by CU/datapath; everything else is
   // consumed inside the fetch sequencer.
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_MOV  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_EQ   = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RSV0 = 4'b1101;
   localparam logic [3:0] OP_RSV1 = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Instruction word layout: [15:12] opcode, [11:6] dst, [5:0] src
   localparam int INSTR_OPC_MSB = 15;
   localparam int INSTR_OPC_LSB = 12;
   localparam int INSTR_DST_MSB = 11;
   localparam int INSTR_DST_LSB = 6;
   localparam int INSTR_SRC_MSB = 5;
   localparam int INSTR_SRC_LSB = 0;

   typedef enum logic [2:0] {
      FS_IDLE   = 3'd0,
      FS_FETCH  = 3'd1,
      FS_DECODE = 3'd2,
      FS_ISSUE  = 3'd3,
      FS_HALTED = 3'd4
   } fetch_state_t;

   // True for opcodes that must be handed to CU (MOV..EQ).
   function automatic logic is_issue_op(input logic [3:0] op);
      return (op >= OP_MOV) && (op <= OP_EQ);
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch
//  Purpose : Instruction fetch/issue sequencer. Holds the PC, reads words from
//            instruction memory over a req/ack handshake, splits them into
//            opcode/dst/src and holds them for CU until exec_done. NOP,
//            reserved opcodes, JMP and HALT are handled locally.
//  Ports   : clk, rst (async, active high), start (pulse from IDLE/HALTED)
//            imem_req/imem_addr out, imem_ack/imem_data in  (fetch handshake)
//            opcode/dst_addr/src_addr/issue_valid out       (issue to CU)
//            exec_done in                                   (datapath done)
//            halted, pc out                                 (status)
//  Rev     : 1.0  initial release
// ============================================================================
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16,
   parameter int OPC_W   = cpu_pkg::OPC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [OPC_W-1:0]   opcode,
   output logic [5:0]         dst_addr,
   output logic [5:0]         src_addr,
   output logic               issue_valid,
   input  logic               exec_done,
   output logic               halted,
   output logic [PC_W-1:0]    pc
);

   fetch_state_t        r_state;
   logic [PC_W-1:0]     r_pc;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_imem_req;
   logic [PC_W-1:0]     r_imem_addr;
   logic [OPC_W-1:0]    r_opcode;
   logic [ADDR_W-1:0]   r_dst;
   logic [ADDR_W-1:0]   r_src;
   logic                r_issue_valid;
   logic                r_halted;

   logic [OPC_W-1:0]    w_opc;
   logic [ADDR_W-1:0]   w_dst;
   logic [ADDR_W-1:0]   w_src;
   logic [PC_W-1:0]     w_pc_inc;
   logic [PC_W-1:0]     w_jmp_target;

   assign w_opc    = r_instr[INSTR_OPC_MSB:INSTR_OPC_LSB];
   assign w_dst    = r_instr[INSTR_DST_MSB:INSTR_DST_LSB];
   assign w_src    = r_instr[INSTR_SRC_MSB:INSTR_SRC_LSB];
   // Natural modulo-2^PC_W wrap, no overflow flag.
   assign w_pc_inc = r_pc + PC_W'(1);
   // Jump target is the concatenated address fields, resized to the PC width.
   assign w_jmp_target = PC_W'({w_dst, w_src});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= FS_IDLE;
         r_pc          <= '0;
         r_instr       <= '0;
         r_imem_req    <= 1'b0;
         r_imem_addr   <= '0;
         r_opcode      <= '0;
         r_dst         <= '0;
         r_src         <= '0;
         r_issue_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            FS_IDLE, FS_HALTED: begin
               if (start) begin
                  r_state     <= FS_FETCH;
                  r_pc        <= '0;
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= '0;
                  r_halted    <= 1'b0;
               end
            end

            FS_FETCH: begin
               // Request is held with no timeout until memory answers.
               if (imem_ack) begin
                  r_instr    <= imem_data;
                  r_imem_req <= 1'b0;
                  r_state    <= FS_DECODE;
               end
            end

            FS_DECODE: begin
               if (w_opc == OP_HALT) begin
                  r_state  <= FS_HALTED;
                  r_halted <= 1'b1;
               end else if (w_opc == OP_JMP) begin
                  r_pc        <= w_jmp_target;
                  r_imem_addr <= w_jmp_target;
                  r_imem_req  <= 1'b1;
                  r_state     <= FS_FETCH;
               end else if (is_issue_op(w_opc)) begin
                  r_state       <= FS_ISSUE;
                  r_issue_valid <= 1'b1;
                  r_opcode      <= w_opc;
                  r_dst         <= w_dst;
                  r_src         <= w_src;
               end else begin
                  // NOP and the two reserved codes just advance the PC.
                  r_pc        <= w_pc_inc;
                  r_imem_addr <= w_pc_inc;
                  r_imem_req  <= 1'b1;
                  r_state     <= FS_FETCH;
               end
            end

            FS_ISSUE: begin
               if (exec_done) begin
                  r_pc          <= w_pc_inc;
                  r_imem_addr   <= w_pc_inc;
                  r_imem_req    <= 1'b1;
                  r_issue_valid <= 1'b0;
                  // CU must see a zero opcode whenever nothing is issued.
                  r_opcode      <= '0;
                  r_dst         <= '0;
                  r_src         <= '0;
                  r_state       <= FS_FETCH;
               end
            end

            default: begin
               r_state <= FS_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_imem_addr;
   assign opcode      = r_opcode;
   assign dst_addr    = r_dst;
   assign src_addr    = r_src;
   assign issue_valid = r_issue_valid;
   assign halted      = r_halted;
   assign pc          = r_pc;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_instr_fetch
//  Purpose : Directed self-checking bench for instr_fetch with a simple
//            instruction-memory responder and an issue monitor.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   logic               clk;
   logic               rst;
   logic               start;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [3:0]         opcode;
   logic [5:0]         dst_addr;
   logic [5:0]         src_addr;
   logic               issue_valid;
   logic               exec_done;
   logic               halted;
   logic [PC_W-1:0]    pc;

   logic [15:0]        mem [0:255];
   int                 ack_delay;
   int                 wait_cnt;
   bit                 auto_en;
   bit                 spur_ack;
   int                 fetch_log [$];

   int                 iv_cnt;
   int                 viol;
   logic [3:0]         last_opc;

   int                 n_checks;
   int                 n_errors;

   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OPC_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .opcode      (opcode),
      .dst_addr    (dst_addr),
      .src_addr    (src_addr),
      .issue_valid (issue_valid),
      .exec_done   (exec_done),
      .halted      (halted),
      .pc          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got timeout required finish");
      $fatal(1);
   end

   // Memory responder: acks after ack_delay cycles of request, or whenever
   // spur_ack is forced high.
   initial begin
      imem_ack  = 1'b0;
      imem_data = '0;
      wait_cnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         imem_ack = spur_ack;
         if (auto_en && imem_req && !spur_ack) begin
            if (wait_cnt >= ack_delay) begin
               imem_ack = 1'b1;
               fetch_log.push_back(int'(imem_addr));
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         imem_data = mem[imem_addr];
      end
   end

   // Issue monitor: counts issue cycles and opcode-nonzero-while-idle events.
   initial begin
      iv_cnt   = 0;
      viol     = 0;
      last_opc = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (issue_valid) begin
               iv_cnt++;
               last_opc = opcode;
            end else if (opcode != 4'd0) begin
               viol++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      exec_done = 1'b0;
      auto_en   = 1'b0;
      spur_ack  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_issue(input int bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (issue_valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_halt(input int bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (halted) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit found;
      int base;
      n_checks  = 0;
      n_errors  = 0;
      ack_delay = 0;
      clear_mem();
      do_reset();

      // ---- 1: reset state, then async reset in the middle of a fetch ----
      @(negedge clk);
      check("rst_req",  imem_req, 1'b0);
      check("rst_pc",   pc, 8'd0);
      check("rst_outs", {issue_valid, halted, opcode, dst_addr, src_addr}, 18'd0);
      pulse_start();
      @(negedge clk);
      check("fetch_req",  imem_req, 1'b1);
      check("fetch_addr", imem_addr, 8'd0);
      #2 rst = 1'b1;
      #1;
      check("midrst_req",  imem_req, 1'b0);
      check("midrst_outs", {issue_valid, halted, opcode, dst_addr, src_addr, pc, imem_addr}, 34'd0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("start_in_rst_ignored", imem_req, 1'b0);

      // ---- 2: ADD issued and held until exec_done ----
      do_reset();
      clear_mem();
      mem[0]    = 16'h2041;
      ack_delay = 2;
      auto_en   = 1'b1;
      pulse_start();
      wait_issue(20, found);
      check("add_issue_seen", found, 1'b1);
      auto_en = 1'b0;
      check("add_fields_c1", {issue_valid, opcode, dst_addr, src_addr}, {1'b1, 4'h2, 6'd1, 6'd1});
      for (int k = 0; k < 3; k++) begin
         start = (k == 0);     // start in ISSUE must be ignored
         @(negedge clk);
         check("add_hold", {issue_valid, opcode, dst_addr, src_addr, pc}, {1'b1, 4'h2, 6'd1, 6'd1, 8'd0});
      end
      start     = 1'b0;
      exec_done = 1'b1;
      @(posedge clk);
      #1 exec_done = 1'b0;
      @(negedge clk);
      check("add_done_iv",   issue_valid, 1'b0);
      check("add_done_opc",  opcode, 4'h0);
      check("add_done_pc",   pc, 8'd1);
      check("add_done_req",  {imem_req, imem_addr}, {1'b1, 8'd1});

      // ---- 3: NOP, JMP 5, HALT; then restart ----
      do_reset();
      clear_mem();
      mem[0]    = 16'h0000;
      mem[1]    = 16'hC005;
      mem[5]    = 16'hF000;
      ack_delay = 1;
      base      = fetch_log.size();
      @(negedge clk);
      auto_en   = 1'b1;
      begin
         int iv0;
         iv0 = iv_cnt;
         pulse_start();
         wait_halt(50, found);
         check("jmp_halt_seen", found, 1'b1);
         check("jmp_no_issue",  iv_cnt - iv0, 0);
      end
      auto_en = 1'b0;
      check("jmp_pc",        pc, 8'd5);
      check("jmp_nfetch",    fetch_log.size() - base, 3);
      if (fetch_log.size() - base == 3) begin
         check("jmp_fa0", fetch_log[base],     0);
         check("jmp_fa1", fetch_log[base + 1], 1);
         check("jmp_fa2", fetch_log[base + 2], 5);
      end
      pulse_start();
      @(negedge clk);
      check("restart", {halted, pc, imem_req, imem_addr}, {1'b0, 8'd0, 1'b1, 8'd0});

      // ---- 4: PC wrap after MOV at 255 ----
      do_reset();
      clear_mem();
      mem[0]    = 16'hC0FF;   // JMP 255
      mem[255]  = 16'h1000;   // MOV
      ack_delay = 0;
      @(negedge clk);
      auto_en   = 1'b1;
      pulse_start();
      wait_issue(30, found);
      check("wrap_issue_seen", found, 1'b1);
      auto_en = 1'b0;
      check("wrap_pre", {opcode, pc}, {4'h1, 8'd255});
      exec_done = 1'b1;
      @(posedge clk);
      #1 exec_done = 1'b0;
      @(negedge clk);
      check("wrap_post", {imem_req, imem_addr, pc}, {1'b1, 8'd0, 8'd0});

      // ---- 5: spurious ack/exec_done, single-cycle issue ----
      do_reset();
      clear_mem();
      mem[0] = 16'h3082;
      mem[1] = 16'hF000;
      @(negedge clk);
      spur_ack  = 1'b1;
      exec_done = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_spurious", {imem_req, imem_addr, pc, halted, issue_valid}, 19'd0);
      begin
         int iv0;
         iv0 = iv_cnt;
         pulse_start();
         wait_halt(30, found);
         check("single_halt_seen", found, 1'b1);
         check("single_iv_cycles", iv_cnt - iv0, 1);
      end
      check("single_opc", last_opc, 4'h3);
      check("single_pc",  pc, 8'd1);
      exec_done = 1'b0;
      spur_ack  = 1'b0;

      check("opc_zero_when_idle", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_instr_fetch
`default_nettype wire
